// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: shared prescaler and frame counter,
// per-channel enable, and angle targets slewed toward at most STEP per frame.
module servo_pwm_multi #(
  parameter int N_CH         = 4,
  parameter int ANGLE_W      = 8,
  parameter int TICK_DIV     = 256,
  parameter int PERIOD_TICKS = 4096,
  parameter int MIN_TICKS    = 165,
  parameter int STEP         = 4,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [ANGLE_W-1:0] wr_angle,
  input  logic               wr_enable,
  output logic [N_CH-1:0]    servo_pwm,
  output logic               frame_start,
  output logic [N_CH-1:0]    settling
);

  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FC_W  = $clog2(PERIOD_TICKS);
  localparam int SUM_W = FC_W + 1;
  localparam logic [ANGLE_W-1:0] CENTRE = ANGLE_W'(1 << (ANGLE_W - 1));

  // The longest pulse must end before the frame does.
  if (N_CH < 1 || TICK_DIV < 1 ||
      MIN_TICKS + (1 << ANGLE_W) - 1 >= PERIOD_TICKS) begin : g_illegal_params
    $error("servo_pwm_multi: illegal parameter combination");
  end

  logic [PS_W-1:0]    prescaler;
  logic [FC_W-1:0]    frame_cnt;
  logic [ANGLE_W-1:0] target [N_CH];
  logic [ANGLE_W-1:0] pos    [N_CH];
  logic [N_CH-1:0]    en_req;
  logic [N_CH-1:0]    en_act;
  logic               tick;
  logic               boundary;
  logic               wr_fire;

  assign tick     = (prescaler == PS_W'(TICK_DIV - 1));
  assign boundary = tick && (frame_cnt == FC_W'(PERIOD_TICKS - 1));
  // Refusing writes on the boundary keeps target stable while pos is updated.
  assign wr_ready = !reset && !boundary;
  assign wr_fire  = wr_valid && wr_ready && (32'(wr_ch) < N_CH);

  // One frame's worth of movement toward the target, never overshooting.
  function automatic logic [ANGLE_W-1:0] slew(input logic [ANGLE_W-1:0] cur,
                                              input logic [ANGLE_W-1:0] tgt);
    if (STEP == 0)
      slew = tgt;
    else if (tgt > cur)
      slew = (32'(tgt - cur) > STEP) ? cur + ANGLE_W'(STEP) : tgt;
    else if (tgt < cur)
      slew = (32'(cur - tgt) > STEP) ? cur - ANGLE_W'(STEP) : tgt;
    else
      slew = cur;
  endfunction

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler   <= '0;
      frame_cnt   <= '0;
      en_req      <= '0;
      en_act      <= '0;
      servo_pwm   <= '0;
      frame_start <= 1'b0;
      // NOTE: target/pos are small per-channel register files, not RAM, so
      // resetting them to centre is cheap and gives a known first frame.
      for (int i = 0; i < N_CH; i++) begin
        target[i] <= CENTRE;
        pos[i]    <= CENTRE;
      end
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick)
        frame_cnt <= (frame_cnt == FC_W'(PERIOD_TICKS - 1)) ? '0 : frame_cnt + 1'b1;
      frame_start <= (frame_cnt == '0) && (prescaler == '0);

      for (int i = 0; i < N_CH; i++)
        servo_pwm[i] <= en_act[i] &&
                        ({1'b0, frame_cnt} < (SUM_W'(MIN_TICKS) + SUM_W'(pos[i])));

      if (boundary) begin
        for (int i = 0; i < N_CH; i++)
          pos[i] <= slew(pos[i], target[i]);
        en_act <= en_req;
      end

      if (wr_fire) begin
        target[wr_ch] <= wr_angle;
        en_req[wr_ch] <= wr_enable;
      end
    end
  end

  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    settling = '0;
    for (int i = 0; i < N_CH; i++)
      settling[i] = (pos[i] != target[i]);
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a ramping 4-channel instance and a jumping (STEP=0)
// 3-channel instance share one write port and are checked against a frame model.
`timescale 1ns/1ps
module tb_servo_pwm_multi;

  localparam int TD = 1, P = 512, MIN = 165, STEP = 4;
  localparam int FRAME = TD * P;
  localparam int NM = 4, NJ = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_enable = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_angle = '0;
  logic       wr_ready_m, wr_ready_j, frame_start_m, frame_start_j;
  logic [3:0] pwm_m, settling_m;
  logic [2:0] pwm_j, settling_j;

  int tests = 0;
  int fails = 0;

  servo_pwm_multi #(.N_CH(NM), .ANGLE_W(8), .TICK_DIV(TD), .PERIOD_TICKS(P),
                    .MIN_TICKS(MIN), .STEP(STEP)) u_dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_m),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .wr_enable(wr_enable),
    .servo_pwm(pwm_m), .frame_start(frame_start_m), .settling(settling_m));

  servo_pwm_multi #(.N_CH(NJ), .ANGLE_W(8), .TICK_DIV(TD), .PERIOD_TICKS(P),
                    .MIN_TICKS(MIN), .STEP(0)) u_jump (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_j),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .wr_enable(wr_enable),
    .servo_pwm(pwm_j), .frame_start(frame_start_j), .settling(settling_j));

  always #5 clock = ~clock;

  // Reference model: m_cyc is the index of the last rising edge since reset;
  // edge c is a frame boundary when c mod FRAME == FRAME-1.
  int m_cyc = -1;
  int tgt_m[NM], pos_m[NM], tgt_j[NJ], pos_j[NJ];
  bit enr_m[NM], ena_m[NM], enr_j[NJ], ena_j[NJ];

  function automatic int slew(int p, int t, int s);
    if (s == 0) return t;
    if (t > p) return (t - p > s) ? p + s : t;
    if (t < p) return (p - t > s) ? p - s : t;
    return p;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_cyc <= -1;
      for (int i = 0; i < NM; i++) begin
        tgt_m[i] <= 128; pos_m[i] <= 128; enr_m[i] <= 1'b0; ena_m[i] <= 1'b0;
      end
      for (int i = 0; i < NJ; i++) begin
        tgt_j[i] <= 128; pos_j[i] <= 128; enr_j[i] <= 1'b0; ena_j[i] <= 1'b0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      if ((m_cyc + 1) % FRAME == FRAME - 1) begin
        for (int i = 0; i < NM; i++) begin
          pos_m[i] <= slew(pos_m[i], tgt_m[i], STEP); ena_m[i] <= enr_m[i];
        end
        for (int i = 0; i < NJ; i++) begin
          pos_j[i] <= slew(pos_j[i], tgt_j[i], 0); ena_j[i] <= enr_j[i];
        end
      end else if (wr_valid) begin
        if (int'(wr_ch) < NM) begin
          tgt_m[wr_ch] <= int'(wr_angle); enr_m[wr_ch] <= wr_enable;
        end
        if (int'(wr_ch) < NJ) begin
          tgt_j[wr_ch] <= int'(wr_angle); enr_j[wr_ch] <= wr_enable;
        end
      end
    end
  end

  // Results of the most recent measured frame.
  int w_m[NM], w_j[NJ], e_m[NM], e_j[NJ];
  logic [3:0] st_m, es_m;
  logic [2:0] st_j, es_j;
  int fs_cnt;
  bit fs_first;

  task automatic sync_frame();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (m_cyc % FRAME != 0 && n <= FRAME + 2);
    tests++;
    if (m_cyc % FRAME != 0) begin
      fails++;
      $display("FAIL sync_frame timeout: cycle %0d not at frame start", m_cyc);
    end
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [7:0] ang, input logic en);
    @(negedge clock);
    if ((m_cyc + 1) % FRAME == FRAME - 1) @(negedge clock);
    wr_ch = ch; wr_angle = ang; wr_enable = en; wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  // Measures one whole frame; optionally issues a single write at offset wr_at.
  task automatic measure_frame(input int wr_at, input logic [1:0] ch,
                               input logic [7:0] ang, input logic en);
    sync_frame();
    for (int i = 0; i < NM; i++) begin
      e_m[i] = ena_m[i] ? (MIN + pos_m[i]) * TD : 0;
      es_m[i] = (pos_m[i] != tgt_m[i]);
      w_m[i] = 0;
    end
    for (int i = 0; i < NJ; i++) begin
      e_j[i] = ena_j[i] ? (MIN + pos_j[i]) * TD : 0;
      es_j[i] = (pos_j[i] != tgt_j[i]);
      w_j[i] = 0;
    end
    st_m = settling_m;
    st_j = settling_j;
    fs_first = frame_start_m && frame_start_j;
    fs_cnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clock);
      for (int i = 0; i < NM; i++) w_m[i] += int'(pwm_m[i]);
      for (int i = 0; i < NJ; i++) w_j[i] += int'(pwm_j[i]);
      fs_cnt += int'(frame_start_m) + int'(frame_start_j);
      if (c == wr_at) begin
        wr_ch = ch; wr_angle = ang; wr_enable = en; wr_valid = 1'b1;
      end else begin
        wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (pwm_m !== 4'b0 || pwm_j !== 3'b0) begin
      fails++; $display("FAIL reset_pwm got %b/%b want 0", pwm_m, pwm_j);
    end
    tests++;
    if (wr_ready_m !== 1'b0 || wr_ready_j !== 1'b0) begin
      fails++; $display("FAIL reset_wr_ready got %b/%b want 0", wr_ready_m, wr_ready_j);
    end
    tests++;
    if (frame_start_m !== 1'b0 || settling_m !== 4'b0 || settling_j !== 3'b0) begin
      fails++; $display("FAIL reset_flags fs %b settling %b/%b want 0", frame_start_m, settling_m, settling_j);
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (frame_start_m !== 1'b1 || frame_start_j !== 1'b1) begin
      fails++; $display("FAIL first_frame_start got %b/%b want 1", frame_start_m, frame_start_j);
    end
    tests++;
    if (wr_ready_m !== 1'b1 || pwm_m !== 4'b0) begin
      fails++; $display("FAIL after_reset ready %b pwm %b want 1/0000", wr_ready_m, pwm_m);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clock);
      tests++;
      if (pwm_m !== 4'b0 || pwm_j !== 3'b0) begin
        fails++; $display("FAIL idle_pwm cyc %0d got %b/%b want 0", m_cyc, pwm_m, pwm_j);
      end
      tests++;
      if (frame_start_m !== (m_cyc % FRAME == 0)) begin
        fails++; $display("FAIL idle_frame_start cyc %0d got %b want %b", m_cyc, frame_start_m, m_cyc % FRAME == 0);
      end
      tests++;
      if (wr_ready_m !== ((m_cyc + 1) % FRAME != FRAME - 1)) begin
        fails++; $display("FAIL idle_wr_ready cyc %0d got %b", m_cyc, wr_ready_m);
      end
      tests++;
      if (settling_m !== 4'b0 || settling_j !== 3'b0) begin
        fails++; $display("FAIL idle_settling cyc %0d got %b/%b want 0", m_cyc, settling_m, settling_j);
      end
    end
  endtask

  task automatic test_jump();
    do_write(2'd0, 8'd128, 1'b1);
    measure_frame(-1, 2'd0, 8'd0, 1'b0);
    tests++;
    if (w_m[0] !== 293 || w_j[0] !== 293) begin
      fails++; $display("FAIL jump_ch0_width got %0d/%0d want 293", w_m[0], w_j[0]);
    end
    tests++;
    if (w_m[1] + w_m[2] + w_m[3] + w_j[1] + w_j[2] !== 0) begin
      fails++; $display("FAIL jump_others_low got %0d %0d %0d want 0", w_m[1], w_m[2], w_m[3]);
    end
    tests++;
    if (!fs_first || fs_cnt !== 2) begin
      fails++; $display("FAIL jump_frame_start first %b count %0d want 1/2", fs_first, fs_cnt);
    end
  endtask

  task automatic test_ramp();
    int up_w[3] = '{297, 301, 305};
    int dn_w[3] = '{301, 297, 294};
    logic st_exp[3] = '{1'b1, 1'b1, 1'b0};
    do_write(2'd1, 8'd140, 1'b1);
    for (int f = 0; f < 3; f++) begin
      measure_frame(-1, 2'd0, 8'd0, 1'b0);
      tests++;
      if (w_m[1] !== up_w[f] || w_j[1] !== 305) begin
        fails++; $display("FAIL ramp_up f%0d got %0d/%0d want %0d/305", f, w_m[1], w_j[1], up_w[f]);
      end
      tests++;
      if (st_m[1] !== st_exp[f] || st_j[1] !== 1'b0) begin
        fails++; $display("FAIL ramp_up_settling f%0d got %b/%b want %b/0", f, st_m[1], st_j[1], st_exp[f]);
      end
    end
    do_write(2'd1, 8'd129, 1'b1);
    for (int f = 0; f < 3; f++) begin
      measure_frame(-1, 2'd0, 8'd0, 1'b0);
      tests++;
      if (w_m[1] !== dn_w[f] || w_j[1] !== 294) begin
        fails++; $display("FAIL ramp_down f%0d got %0d/%0d want %0d/294", f, w_m[1], w_j[1], dn_w[f]);
      end
      tests++;
      if (st_m[1] !== st_exp[f]) begin
        fails++; $display("FAIL ramp_down_settling f%0d got %b want %b", f, st_m[1], st_exp[f]);
      end
    end
  endtask

  task automatic test_extremes();
    do_write(2'd2, 8'd0, 1'b1);
    do_write(2'd3, 8'd255, 1'b1);
    for (int f = 0; f < 33; f++) begin
      measure_frame(-1, 2'd0, 8'd0, 1'b0);
      if (f == 0) begin
        tests++;
        if (w_j[2] !== 165) begin
          fails++; $display("FAIL extreme_jump_ch2 got %0d want 165", w_j[2]);
        end
      end
      for (int i = 0; i < NM; i++) begin
        tests++;
        if (w_m[i] !== e_m[i]) begin
          fails++; $display("FAIL extreme_model f%0d ch%0d got %0d want %0d", f, i, w_m[i], e_m[i]);
        end
      end
    end
    tests++;
    if (w_m[2] !== 165 || w_m[3] !== 420) begin
      fails++; $display("FAIL extreme_final got %0d/%0d want 165/420", w_m[2], w_m[3]);
    end
    tests++;
    if (st_m !== 4'b0 || st_j !== 3'b0) begin
      fails++; $display("FAIL extreme_settled got %b/%b want 0", st_m, st_j);
    end
    tests++;
    if (w_j[0] !== 293 || w_j[1] !== 294 || w_j[2] !== 165) begin
      fails++; $display("FAIL discard_ch3 jump widths %0d %0d %0d want 293 294 165", w_j[0], w_j[1], w_j[2]);
    end
  endtask

  task automatic test_boundary_write();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (m_cyc % FRAME != FRAME - 2 && n <= 2 * FRAME);
    wr_ch = 2'd0; wr_angle = 8'd60; wr_enable = 1'b1; wr_valid = 1'b1;
    tests++;
    if (wr_ready_m !== 1'b0 || wr_ready_j !== 1'b0) begin
      fails++; $display("FAIL boundary_refuse got %b/%b want 0", wr_ready_m, wr_ready_j);
    end
    @(negedge clock);
    tests++;
    if (wr_ready_m !== 1'b1 || settling_m[0] !== 1'b0) begin
      fails++; $display("FAIL boundary_retry ready %b settling %b want 1/0", wr_ready_m, settling_m[0]);
    end
    @(negedge clock);
    wr_valid = 1'b0;
    tests++;
    if (settling_m[0] !== 1'b1 || settling_j[0] !== 1'b1) begin
      fails++; $display("FAIL boundary_accepted settling %b/%b want 1/1", settling_m[0], settling_j[0]);
    end
    measure_frame(-1, 2'd0, 8'd0, 1'b0);
    tests++;
    if (w_m[0] !== 289 || w_j[0] !== 225) begin
      fails++; $display("FAIL boundary_applied got %0d/%0d want 289/225", w_m[0], w_j[0]);
    end
  endtask

  task automatic test_disable_midpulse();
    measure_frame(50, 2'd0, 8'd60, 1'b0);
    tests++;
    if (w_m[0] !== 285 || w_j[0] !== 225) begin
      fails++; $display("FAIL disable_full_pulse got %0d/%0d want 285/225", w_m[0], w_j[0]);
    end
    measure_frame(-1, 2'd0, 8'd0, 1'b0);
    tests++;
    if (w_m[0] !== 0 || w_j[0] !== 0) begin
      fails++; $display("FAIL disable_next_low got %0d/%0d want 0", w_m[0], w_j[0]);
    end
    tests++;
    if (st_m[0] !== 1'b1 || st_j[0] !== 1'b0) begin
      fails++; $display("FAIL disable_settling got %b/%b want 1/0", st_m[0], st_j[0]);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      logic [1:0] ch = 2'($urandom_range(0, 3));
      logic [7:0] ang = 8'($urandom_range(0, 255));
      logic en = 1'($urandom_range(0, 1));
      measure_frame(int'($urandom_range(1, FRAME - 3)), ch, ang, en);
      for (int i = 0; i < NM; i++) begin
        tests++;
        if (w_m[i] !== e_m[i]) begin
          fails++; $display("FAIL random f%0d ramp ch%0d got %0d want %0d", f, i, w_m[i], e_m[i]);
        end
      end
      for (int i = 0; i < NJ; i++) begin
        tests++;
        if (w_j[i] !== e_j[i]) begin
          fails++; $display("FAIL random f%0d jump ch%0d got %0d want %0d", f, i, w_j[i], e_j[i]);
        end
      end
      tests++;
      if (st_m !== es_m || st_j !== es_j || !fs_first || fs_cnt !== 2) begin
        fails++; $display("FAIL random f%0d flags settling %b/%b want %b/%b fs %b/%0d", f, st_m, st_j, es_m, es_j, fs_first, fs_cnt);
      end
    end
  endtask

  task automatic test_reset_midpulse();
    do_write(2'd1, 8'd200, 1'b1);
    measure_frame(-1, 2'd0, 8'd0, 1'b0);
    sync_frame();
    repeat (20) @(negedge clock);
    tests++;
    if (pwm_m[1] !== 1'b1 || pwm_j[1] !== 1'b1) begin
      fails++; $display("FAIL pre_reset_pulse got %b/%b want 1", pwm_m[1], pwm_j[1]);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (pwm_m !== 4'b0 || pwm_j !== 3'b0 || frame_start_m !== 1'b0 || wr_ready_m !== 1'b0) begin
      fails++; $display("FAIL reset_midpulse pwm %b/%b fs %b ready %b want 0", pwm_m, pwm_j, frame_start_m, wr_ready_m);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (frame_start_m !== 1'b1 || settling_m !== 4'b0 || settling_j !== 3'b0) begin
      fails++; $display("FAIL restart fs %b settling %b/%b want 1/0/0", frame_start_m, settling_m, settling_j);
    end
    measure_frame(-1, 2'd0, 8'd0, 1'b0);
    tests++;
    if (w_m[0] + w_m[1] + w_m[2] + w_m[3] + w_j[0] + w_j[1] + w_j[2] !== 0) begin
      fails++; $display("FAIL restart_disabled ch1 got %0d/%0d want 0", w_m[1], w_j[1]);
    end
    do_write(2'd0, 8'd128, 1'b1);
    measure_frame(-1, 2'd0, 8'd0, 1'b0);
    tests++;
    if (w_m[0] !== 293 || w_j[0] !== 293 || st_m !== 4'b0 || w_m[1] !== 0) begin
      fails++; $display("FAIL restart_centre got %0d/%0d settling %b ch1 %0d want 293/293/0000/0", w_m[0], w_j[0], st_m, w_m[1]);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_jump();
    test_ramp();
    test_extremes();
    test_boundary_write();
    test_disable_midpulse();
    test_random();
    test_reset_midpulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
